// File: rtl/dac_burst_ctrl.sv
// -----------------------------------------------------------------------------
// dac_burst_ctrl
//
// Multi-channel output stage between per-DAC waveform sources and the DAC
// batch interface. Every channel is independent and has its own IDLE/RUN FSM.
// Each channel:
//   - gates batch flow with start/halt pulses,
//   - arithmetic-right-shifts every sample of an accepted batch by
//     scale_factor,
//   - registers the batch with one cycle of latency and holds it under
//     back-pressure,
//   - counts issued and delivered batches against a latched burst size
//     (0 = continuous),
//   - reports the number of delivered batches of the last run on halt_counter.
//
// Optional feature (compile-time macro DAC_BURST_OFFSET_EN):
//   When the macro is defined, the signed per-channel offset is added to each
//   shifted sample, saturating to the signed DATA_WIDTH range. Latency is
//   unchanged. When the macro is undefined, the offset port is ignored.
//
// Ports (all per-channel vectors are indexed [channel]):
//   dac_clk        in   sole clock
//   dac_rst_n      in   asynchronous active-low reset
//   start          in   per-channel start pulse (honoured only in IDLE)
//   halt           in   per-channel halt pulse (wins over start)
//   scale_factor   in   right-shift amount, sampled on source accept
//   burst_size     in   batches per burst, latched on start; 0 = continuous
//   offset         in   signed offset (used only with DAC_BURST_OFFSET_EN)
//   src_batch      in   source batch, BATCH_SIZE signed samples
//   src_valid      in   source batch valid
//   src_ready      out  channel can take a source batch this cycle
//   dac_batch      out  registered scaled batch
//   dac_valid      out  dac_batch holds an undelivered batch
//   dac_rdy        in   DAC accepts dac_batch this cycle
//   intf_rdy       out  channel is IDLE and will accept start
//   burst_done     out  one-cycle pulse when a finite burst completes
//   halt_counter   out  batches delivered during the last finished run
// -----------------------------------------------------------------------------
module dac_burst_ctrl #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned BATCH_SIZE = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_BURST  = 64,
    parameter int unsigned BS_WIDTH   = $clog2(MAX_BURST) + 1,
    localparam int unsigned SF_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                                             dac_clk,
    input  logic                                             dac_rst_n,
    input  logic [NUM_CH-1:0]                                start,
    input  logic [NUM_CH-1:0]                                halt,
    input  logic [NUM_CH-1:0][SF_WIDTH-1:0]                  scale_factor,
    input  logic [NUM_CH-1:0][BS_WIDTH-1:0]                  burst_size,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]                offset,
    input  logic [NUM_CH-1:0][BATCH_SIZE-1:0][DATA_WIDTH-1:0] src_batch,
    input  logic [NUM_CH-1:0]                                src_valid,
    output logic [NUM_CH-1:0]                                src_ready,
    output logic [NUM_CH-1:0][BATCH_SIZE-1:0][DATA_WIDTH-1:0] dac_batch,
    output logic [NUM_CH-1:0]                                dac_valid,
    input  logic [NUM_CH-1:0]                                dac_rdy,
    output logic [NUM_CH-1:0]                                intf_rdy,
    output logic [NUM_CH-1:0]                                burst_done,
    output logic [NUM_CH-1:0][BS_WIDTH-1:0]                  halt_counter
);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    typedef logic [BATCH_SIZE-1:0][DATA_WIDTH-1:0] batch_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e                          state_q [NUM_CH];
    state_e                          state_d [NUM_CH];
    logic [NUM_CH-1:0][BS_WIDTH-1:0] bs_q, bs_d;
    logic [NUM_CH-1:0][BS_WIDTH-1:0] issued_q, issued_d;
    logic [NUM_CH-1:0][BS_WIDTH-1:0] deliv_q, deliv_d;
    logic [NUM_CH-1:0][BS_WIDTH-1:0] halt_cnt_q, halt_cnt_d;
    logic [NUM_CH-1:0]               dac_valid_q, dac_valid_d;
    logic [NUM_CH-1:0]               burst_done_q, burst_done_d;
    batch_t [NUM_CH-1:0]             dac_batch_q, dac_batch_d;

    // Per-channel helper terms, fully assigned every evaluation
    logic [NUM_CH-1:0]               deliver;
    logic [NUM_CH-1:0]               accept;
    logic [NUM_CH-1:0]               has_room;
    logic [NUM_CH-1:0][BS_WIDTH-1:0] deliv_inc;
    logic [NUM_CH-1:0][BS_WIDTH-1:0] issued_inc;
    batch_t [NUM_CH-1:0]             scaled;

    // -------------------------------------------------------------------------
    // Sample datapath
    // -------------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] shift_sample(
        input logic [DATA_WIDTH-1:0] s,
        input logic [SF_WIDTH-1:0]   sf
    );
        logic signed [DATA_WIDTH-1:0] ss;
        ss = $signed(s);
        return DATA_WIDTH'(ss >>> sf);
    endfunction

`ifdef DAC_BURST_OFFSET_EN
    // One guard bit detects overflow; clamp to the signed range on overflow.
    function automatic logic [DATA_WIDTH-1:0] sat_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] sum;
        sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            return sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return sum[DATA_WIDTH-1:0];
    endfunction
`else
    logic unused_offset;
    assign unused_offset = ^offset;
`endif

    always_comb begin
        scaled = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < BATCH_SIZE; i++) begin
`ifdef DAC_BURST_OFFSET_EN
                scaled[c][i] = sat_add(shift_sample(src_batch[c][i], scale_factor[c]),
                                       offset[c]);
`else
                scaled[c][i] = shift_sample(src_batch[c][i], scale_factor[c]);
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Handshake terms
    // -------------------------------------------------------------------------
    always_comb begin
        deliver    = '0;
        accept     = '0;
        has_room   = '0;
        src_ready  = '0;
        intf_rdy   = '0;
        deliv_inc  = '0;
        issued_inc = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            deliver[c]  = dac_valid_q[c] & dac_rdy[c];
            has_room[c] = (bs_q[c] == '0) || (issued_q[c] < bs_q[c]);
            // The output register can take a new batch when empty or draining now
            src_ready[c] = (state_q[c] == StRun) & ~halt[c] & has_room[c]
                         & (~dac_valid_q[c] | dac_rdy[c]);
            accept[c]   = src_valid[c] & src_ready[c];
            intf_rdy[c] = (state_q[c] == StIdle);
            // Counters saturate so continuous mode never wraps
            deliv_inc[c]  = (&deliv_q[c])  ? deliv_q[c]  : deliv_q[c]  + BS_WIDTH'(1);
            issued_inc[c] = (&issued_q[c]) ? issued_q[c] : issued_q[c] + BS_WIDTH'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        bs_d         = bs_q;
        issued_d     = issued_q;
        deliv_d      = deliv_q;
        halt_cnt_d   = halt_cnt_q;
        dac_valid_d  = dac_valid_q;
        dac_batch_d  = dac_batch_q;
        burst_done_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
        end

        for (int c = 0; c < NUM_CH; c++) begin
            unique case (state_q[c])
                StIdle: begin
                    // halt wins over a simultaneous start
                    if (start[c] && !halt[c]) begin
                        state_d[c]  = StRun;
                        bs_d[c]     = burst_size[c];
                        issued_d[c] = '0;
                        deliv_d[c]  = '0;
                    end
                end

                StRun: begin
                    if (halt[c]) begin
                        // Pending batch is dropped; a delivery this cycle still counts
                        state_d[c]     = StIdle;
                        dac_valid_d[c] = 1'b0;
                        halt_cnt_d[c]  = deliver[c] ? deliv_inc[c] : deliv_q[c];
                    end else begin
                        if (deliver[c]) begin
                            deliv_d[c]     = deliv_inc[c];
                            dac_valid_d[c] = 1'b0;
                        end
                        if (accept[c]) begin
                            dac_valid_d[c] = 1'b1;
                            dac_batch_d[c] = scaled[c];
                            issued_d[c]    = issued_inc[c];
                        end
                        // Final delivery implies issued == bs, so no accept collides here
                        if (deliver[c] && (bs_q[c] != '0) && (deliv_inc[c] == bs_q[c])) begin
                            state_d[c]      = StIdle;
                            dac_valid_d[c]  = 1'b0;
                            burst_done_d[c] = 1'b1;
                            halt_cnt_d[c]   = bs_q[c];
                        end
                    end
                end

                default: state_d[c] = StIdle;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge dac_clk or negedge dac_rst_n) begin
        if (!dac_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= StIdle;
            end
            bs_q         <= '0;
            issued_q     <= '0;
            deliv_q      <= '0;
            halt_cnt_q   <= '0;
            dac_valid_q  <= '0;
            burst_done_q <= '0;
            dac_batch_q  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
            end
            bs_q         <= bs_d;
            issued_q     <= issued_d;
            deliv_q      <= deliv_d;
            halt_cnt_q   <= halt_cnt_d;
            dac_valid_q  <= dac_valid_d;
            burst_done_q <= burst_done_d;
            dac_batch_q  <= dac_batch_d;
        end
    end

    assign dac_valid    = dac_valid_q;
    assign dac_batch    = dac_batch_q;
    assign burst_done   = burst_done_q;
    assign halt_counter = halt_cnt_q;

endmodule
